// File: rtl/conv1_maxpool_pkg.sv
// Shared definitions for the conv1 max-pooling stage of the LeNet datapath.
package conv1_maxpool_pkg;

  // Default width of one conv1 output pixel (signed two's complement).
  localparam int OPERAND_WDTH = 19;

  // One conv1 output pixel at the default width.
  typedef logic signed [OPERAND_WDTH-1:0] pixel_t;

endpackage : conv1_maxpool_pkg

// File: rtl/conv1_max2.sv
// Combinational signed two-input maximum, the leaf of the 2x2 pooling tree.
module conv1_max2
  import conv1_maxpool_pkg::*;
#(
  parameter int WDTH = OPERAND_WDTH
) (
  input  logic signed [WDTH-1:0] a,
  input  logic signed [WDTH-1:0] b,
  output logic signed [WDTH-1:0] y
);

  // Both operands are declared signed, so the comparison is two's complement.
  // On a tie either operand is the same value, so the choice does not matter.
  assign y = (a >= b) ? a : b;

endmodule : conv1_max2

// File: rtl/conv1_maxpool.sv
// 2x2 non-overlapping max pooling over two vertically adjacent conv1 rows.
// Each window's maximum is registered, giving one cycle of latency at full
// throughput. The output register is the only state in the block.
module conv1_maxpool
  import conv1_maxpool_pkg::*;
#(
  parameter int OPERAND_WDTH    = conv1_maxpool_pkg::OPERAND_WDTH,
  parameter int NUM_PIXELS_BUF  = 4,
  parameter int NUM_PIXELS_POOL = 2
) (
  input  logic                                             conv1_pool_clk,
  input  logic                                             conv1_pool_rst,
  input  logic [NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]      conv1_pool_a_i,
  input  logic [NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]      conv1_pool_b_i,
  output logic [NUM_PIXELS_POOL-1:0][OPERAND_WDTH-1:0]     conv1_max_pool_o
);

  // Each output pixel consumes exactly two pixels from each row.
  if (NUM_PIXELS_BUF != 2 * NUM_PIXELS_POOL) begin : gen_param_check
    $error("conv1_maxpool: NUM_PIXELS_BUF must equal 2*NUM_PIXELS_POOL");
  end

  // Combinational window maxima, one per pooled pixel.
  logic [NUM_PIXELS_POOL-1:0][OPERAND_WDTH-1:0] pooled;

  for (genvar i = 0; i < NUM_PIXELS_POOL; i++) begin : gen_win
    logic signed [OPERAND_WDTH-1:0] row_a_max;
    logic signed [OPERAND_WDTH-1:0] row_b_max;
    logic signed [OPERAND_WDTH-1:0] win_max;

    // Horizontal pair maximum in row A.
    conv1_max2 #(.WDTH(OPERAND_WDTH)) u_max_a (
      .a (conv1_pool_a_i[2*i]),
      .b (conv1_pool_a_i[2*i+1]),
      .y (row_a_max)
    );

    // Horizontal pair maximum in row B.
    conv1_max2 #(.WDTH(OPERAND_WDTH)) u_max_b (
      .a (conv1_pool_b_i[2*i]),
      .b (conv1_pool_b_i[2*i+1]),
      .y (row_b_max)
    );

    // Vertical combine of the two pair maxima gives the window maximum.
    conv1_max2 #(.WDTH(OPERAND_WDTH)) u_max_ab (
      .a (row_a_max),
      .b (row_b_max),
      .y (win_max)
    );

    assign pooled[i] = win_max;
  end : gen_win

  // Output register: synchronous reset wins over data; otherwise load every cycle.
  always_ff @(posedge conv1_pool_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering in simulation.
    if (conv1_pool_rst) begin
      conv1_max_pool_o <= '0;
    end else begin
      conv1_max_pool_o <= pooled;
    end
  end

endmodule : conv1_maxpool

// File: tb/tb_conv1_maxpool.sv
// Scoreboard bench for conv1_maxpool: the driver pushes the expected pooled
// output for each input set, and a monitor pops and compares one cycle later.
module tb_conv1_maxpool;

  localparam int OW = 19;
  localparam int NB = 4;
  localparam int NP = 2;

  typedef logic [NB-1:0][OW-1:0] row_t;
  typedef logic [NP-1:0][OW-1:0] out_t;

  typedef struct {
    out_t  val;
    string name;
  } exp_t;

  localparam logic [OW-1:0] MAX_POS = 19'h3FFFF;
  localparam logic [OW-1:0] MAX_NEG = 19'h40000;
  localparam logic [OW-1:0] NEG_ONE = 19'h7FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  row_t a_in = '0;
  row_t b_in = '0;
  out_t dut_out;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  conv1_maxpool #(
    .OPERAND_WDTH    (OW),
    .NUM_PIXELS_BUF  (NB),
    .NUM_PIXELS_POOL (NP)
  ) dut (
    .conv1_pool_clk   (clk),
    .conv1_pool_rst   (rst),
    .conv1_pool_a_i   (a_in),
    .conv1_pool_b_i   (b_in),
    .conv1_max_pool_o (dut_out)
  );

  always #5 clk = ~clk;

  // Compare one observed output against its expected value.
  task automatic check(input string name, input out_t actual, input out_t expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got out[1]=%h out[0]=%h, expected out[1]=%h out[0]=%h",
               name, actual[1], actual[0], expected[1], expected[0]);
    end
  endtask

  // Independent reference: linear scan of the four window pixels, signed compare.
  function automatic out_t ref_pool(input row_t a, input row_t b);
    out_t r;
    logic signed [OW-1:0] win [4];
    logic signed [OW-1:0] best;
    for (int i = 0; i < NP; i++) begin
      win[0] = a[2*i];
      win[1] = a[2*i+1];
      win[2] = b[2*i];
      win[3] = b[2*i+1];
      best = win[0];
      for (int k = 1; k < 4; k++) begin
        if (win[k] > best) best = win[k];
      end
      r[i] = best;
    end
    return r;
  endfunction

  // Drive one input set on the falling edge and record what must appear after
  // the following rising edge.
  task automatic apply(input row_t a, input row_t b, input logic r,
                       input out_t expected, input string name);
    exp_t e;
    @(negedge clk);
    a_in = a;
    b_in = b;
    rst  = r;
    e.val  = expected;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: the output register updates every edge, so each edge retires one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, dut_out, e.val);
      end
    end
  end

  // Directed and random stimulus.
  initial begin
    row_t a, b;
    out_t ex;
    int   wait_cycles;

    // Reset held for two edges with nonzero inputs.
    for (int k = 0; k < NB; k++) begin
      a[k] = 19'h12345 + OW'(k);
      b[k] = 19'h0ABCD + OW'(k);
    end
    apply(a, b, 1'b1, '0, "reset_edge0");
    apply(a, b, 1'b1, '0, "reset_edge1");

    // Mixed signs; index 0 listed first.
    a[0] = 19'b1000010111010101000;
    a[1] = 19'b1000101010101010101;
    a[2] = NEG_ONE;
    a[3] = NEG_ONE;
    b[0] = 19'b1111111110101010101;
    b[1] = 19'b1000101010101010101;
    b[2] = 19'h00001;
    b[3] = 19'h00000;
    ex[0] = 19'b1111111110101010101;
    ex[1] = 19'h00001;
    apply(a, b, 1'b0, ex, "mixed_signs");

    // All -1.
    for (int k = 0; k < NB; k++) begin
      a[k] = NEG_ONE;
      b[k] = NEG_ONE;
    end
    ex[0] = NEG_ONE;
    ex[1] = NEG_ONE;
    apply(a, b, 1'b0, ex, "all_neg_one");

    // Mixed positives.
    a[0] = 19'h00000;
    a[1] = 19'h00000;
    a[2] = 19'h00000;
    a[3] = NEG_ONE;
    b[0] = 19'h00000;
    b[1] = 19'b0111000000000000000;
    b[2] = 19'b0000000000111110001;
    b[3] = 19'h00001;
    ex[0] = 19'b0111000000000000000;
    ex[1] = 19'b0000000000111110001;
    apply(a, b, 1'b0, ex, "mixed_pos");

    // Most positive value in each window position in turn, most negative elsewhere.
    ex[0] = MAX_POS;
    ex[1] = MAX_POS;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < NB; k++) begin
        a[k] = MAX_NEG;
        b[k] = MAX_NEG;
      end
      for (int i = 0; i < NP; i++) begin
        case (p)
          0: a[2*i]   = MAX_POS;
          1: a[2*i+1] = MAX_POS;
          2: b[2*i]   = MAX_POS;
          default: b[2*i+1] = MAX_POS;
        endcase
      end
      apply(a, b, 1'b0, ex, $sformatf("extreme_pos%0d", p));
    end

    // Reset mid-stream: the coincident input set is discarded.
    apply(a, b, 1'b1, '0, "midstream_reset");
    for (int k = 0; k < NB; k++) begin
      a[k] = MAX_NEG;
      b[k] = MAX_NEG;
    end
    a[1] = 19'h00123;
    b[2] = 19'h7FF00;
    ex[0] = 19'h00123;
    ex[1] = 19'h7FF00;
    apply(a, b, 1'b0, ex, "resume_after_reset");

    // Back-to-back random vectors against the reference model.
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < NB; k++) begin
        a[k] = OW'($urandom);
        b[k] = OW'($urandom);
      end
      apply(a, b, 1'b0, ref_pool(a, b), "random");
    end

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_conv1_maxpool
